// File: rtl/lsu_dmem_ctrl.sv
// Load/store initiator for the word-addressed data memory. Accepts one
// byte/half/word request at a time, checks alignment, range and the PMP
// verdict, performs the access (read-modify-write for sub-word stores) and
// returns extended load data or a fault code via a valid/ready response.
module lsu_dmem_ctrl #(
  parameter int MEM_AW = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       chk_addr,
  output logic              chk_write,
  input  logic              chk_ok,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_fault
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] FAULT_NONE   = 2'b00;
  localparam logic [1:0] FAULT_ALIGN  = 2'b01;
  localparam logic [1:0] FAULT_ACCESS = 2'b10;

  // First byte address beyond the memory.
  localparam logic [31:0] MEM_BYTES = 32'd4 << MEM_AW;

  state_t      state, next_state;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic        unsigned_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic [1:0]  fault_q;

  logic [1:0]  fault_code;
  logic [4:0]  lane_shift;
  logic [31:0] lane_data;
  logic [31:0] load_value;
  logic [31:0] merge_value;

  // Moore outputs: every strobe is a pure function of the current state, so
  // an asynchronous reset of the state register drops them immediately.
  assign req_ready = (state == IDLE);
  assign mem_read  = (state == LOAD) || (state == RMW_RD);
  assign mem_write = (state == WRITE);
  assign rsp_valid = (state == RESP);
  assign mem_wdata = (state == WRITE) ? merged_q : 32'd0;
  assign mem_addr  = addr_q[MEM_AW+1:2];
  assign chk_addr  = addr_q;
  assign chk_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;

  // Fault classification with priority misaligned > range > PMP.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    fault_code = FAULT_NONE;
    if ((size_q == 2'b11) ||
        (size_q == SIZE_HALF && addr_q[0]) ||
        (size_q == SIZE_WORD && addr_q[1:0] != 2'b00)) begin
      fault_code = FAULT_ALIGN;
    end else if (addr_q >= MEM_BYTES || !chk_ok) begin
      fault_code = FAULT_ACCESS;
    end
  end

  // Little-endian lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    lane_shift = {addr_q[1:0], 3'b000};
    lane_data  = mem_rdata >> lane_shift;
    load_value = mem_rdata;
    merge_value = mem_rdata;
    case (size_q)
      SIZE_BYTE: begin
        load_value  = unsigned_q ? {24'd0, lane_data[7:0]}
                                 : {{24{lane_data[7]}}, lane_data[7:0]};
        merge_value = (mem_rdata & ~(32'h0000_00FF << lane_shift)) |
                      ({24'd0, wdata_q[7:0]} << lane_shift);
      end
      SIZE_HALF: begin
        load_value  = unsigned_q ? {16'd0, lane_data[15:0]}
                                 : {{16{lane_data[15]}}, lane_data[15:0]};
        merge_value = (mem_rdata & ~(32'h0000_FFFF << lane_shift)) |
                      ({16'd0, wdata_q[15:0]} << lane_shift);
      end
      default: begin
        load_value  = mem_rdata;
        merge_value = mem_rdata;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples its inputs from before the edge, independent of block order.
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = CHECK;
      CHECK: begin
        if (fault_code != FAULT_NONE)  next_state = RESP;
        else if (!write_q)             next_state = LOAD;
        else if (size_q == SIZE_WORD)  next_state = WRITE;
        else                           next_state = RMW_RD;
      end
      LOAD:    next_state = RESP;
      RMW_RD:  next_state = WRITE;
      WRITE:   next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, write-data staging and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      merged_q   <= '0;
      rdata_q    <= '0;
      fault_q    <= FAULT_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
          end
        end
        CHECK: begin
          fault_q  <= fault_code;
          rdata_q  <= '0;
          merged_q <= wdata_q;
        end
        LOAD:    rdata_q  <= load_value;
        RMW_RD:  merged_q <= merge_value;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl: a behavioural DataMem, a
// transaction-level reference model with its own memory image, directed
// cases and randomized requests.
module tb_lsu_dmem_ctrl;

  localparam int MEM_AW = 9;
  localparam int DEPTH  = 1 << MEM_AW;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic [31:0]       chk_addr;
  logic              chk_write;
  logic              chk_ok;
  logic              mem_read;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_fault;

  int total = 0;
  int bad   = 0;

  lsu_dmem_ctrl #(.MEM_AW(MEM_AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .chk_addr     (chk_addr),
    .chk_write    (chk_write),
    .chk_ok       (chk_ok),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DataMem: combinational read, write on the rising edge.
  logic [31:0] dm [DEPTH];
  logic        pre_en;
  int          pre_idx;
  logic [31:0] pre_val;

  assign mem_rdata = dm[mem_addr];

  always @(posedge clk) begin
    if (pre_en) dm[pre_idx] <= pre_val;
    else if (mem_write) dm[mem_addr] <= mem_wdata;
  end

  // Reference memory image, updated only by the transaction model.
  logic [31:0] ref_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Transaction model: fault, response data, latency, strobe counts and the
  // word written, derived byte-by-byte from the request.
  task automatic model(input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd, input logic ok,
                       output logic [1:0] f, output logic [31:0] rd, output int lat,
                       output int nrd, output int nwr, output logic [31:0] wword);
    int nbytes;
    int base;
    logic [31:0] word;
    logic [31:0] v;
    nbytes = 1 << sz;
    base   = int'(a % 4);
    rd = 0; nrd = 0; nwr = 0; wword = 0; lat = 1;
    if (sz == 2'b11 || (a % nbytes) != 0) f = 2'b01;
    else if (a >= 32'(4 * DEPTH) || !ok)  f = 2'b10;
    else                                  f = 2'b00;
    if (f != 2'b00) return;
    word = ref_mem[a / 4];
    if (!w) begin
      lat = 2;
      nrd = 1;
      v = 0;
      for (int i = 0; i < nbytes; i++)
        v = v | (((word >> (8 * (base + i))) & 32'hFF) << (8 * i));
      if (!uns && nbytes < 4 && v[8 * nbytes - 1])
        v = v | (32'hFFFF_FFFF << (8 * nbytes));
      rd = v;
    end else begin
      nwr = 1;
      lat = (nbytes == 4) ? 2 : 3;
      nrd = (nbytes == 4) ? 0 : 1;
      for (int i = 0; i < nbytes; i++)
        word = (word & ~(32'hFF << (8 * (base + i)))) |
               (((wd >> (8 * i)) & 32'hFF) << (8 * (base + i)));
      wword = word;
      ref_mem[a / 4] = word;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete request/response transaction checked against the model.
  task automatic run_req(input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd, input logic ok,
                         input int hold, output logic [31:0] got_rdata,
                         output logic [1:0] got_fault);
    logic [1:0]  ef;
    logic [31:0] erd, ewword, wseen;
    int elat, enrd, enwr, k, nrd, nwr;
    logic both, leak, addr_bad, done;
    model(w, a, sz, uns, wd, ok, ef, erd, elat, enrd, enwr, ewword);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz;
    req_unsigned = uns; req_wdata = wd; chk_ok = ok;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = $urandom;
    k = 0; nrd = 0; nwr = 0; wseen = 0;
    both = 0; leak = 0; addr_bad = 0; done = 0;
    while (!done && k < 12) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check("chk_addr", chk_addr, a);
        check("chk_write", 32'(chk_write), 32'(w));
        check("req_ready_busy", 32'(req_ready), 32'd0);
      end
      if (mem_read && mem_write) both = 1;
      if (!mem_write && mem_wdata != 0) leak = 1;
      if ((mem_read || mem_write) && mem_addr != a[MEM_AW+1:2]) addr_bad = 1;
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; wseen = mem_wdata; end
      if (rsp_valid) done = 1;
    end
    got_rdata = rsp_rdata;
    got_fault = rsp_fault;
    check("rsp_latency", 32'(k - 1), 32'(elat));
    if (!done) begin
      do_reset();
      return;
    end
    check("rsp_fault", 32'(rsp_fault), 32'(ef));
    check("rsp_rdata", rsp_rdata, erd);
    check("read_cycles", 32'(nrd), 32'(enrd));
    check("write_cycles", 32'(nwr), 32'(enwr));
    if (enwr != 0) check("write_data", wseen, ewword);
    check("strobe_overlap", 32'(both), 32'd0);
    check("wdata_outside_write", 32'(leak), 32'd0);
    check("mem_addr", 32'(addr_bad), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_ready", 32'(req_ready), 32'd0);
      check("hold_rdata", rsp_rdata, erd);
      check("hold_fault", 32'(rsp_fault), 32'(ef));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("ready_rise", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  f;
    logic [31:0] a;
    int k;
    int nmis;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = '0; req_unsigned = 1'b0; req_wdata = '0; chk_ok = 1'b1;
    rsp_ready = 1'b0; pre_en = 1'b0; pre_idx = 0; pre_val = '0;

    // Preload both images while reset is held; a pending request must be ignored.
    #2;
    req_valid = 1'b1; req_addr = 32'h0000_0123; req_write = 1'b1;
    pre_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      case (i)
        256:     pre_val = 32'h1234_5678;
        257:     pre_val = 32'h9ABC_DEF0;
        2:       pre_val = 32'h0000_0003;
        4:       pre_val = 32'hCAFE_F00D;
        default: pre_val = $urandom;
      endcase
      pre_idx = i;
      ref_mem[i] = pre_val;
      @(posedge clk);
      #1;
    end
    pre_en = 1'b0;

    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_chk_addr", chk_addr, 32'd0);
    check("rst_chk_write", 32'(chk_write), 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(req_ready), 32'd1);
    check("post_rst_chk_addr", chk_addr, 32'd0);

    // Directed cases.
    run_req(1'b0, 32'h400, 2'b10, 1'b0, 32'd0, 1'b1, 0, r, f);
    check("word_load_400", r, 32'h1234_5678);
    run_req(1'b0, 32'h405, 2'b00, 1'b0, 32'd0, 1'b1, 0, r, f);
    check("byte_load_signed", r, 32'hFFFF_FFDE);
    run_req(1'b0, 32'h405, 2'b00, 1'b1, 32'd0, 1'b1, 0, r, f);
    check("byte_load_unsigned", r, 32'h0000_00DE);
    run_req(1'b0, 32'h406, 2'b01, 1'b0, 32'd0, 1'b1, 0, r, f);
    check("half_load_signed", r, 32'hFFFF_9ABC);
    run_req(1'b1, 32'h009, 2'b00, 1'b0, 32'h0000_00AA, 1'b1, 0, r, f);
    run_req(1'b0, 32'h008, 2'b10, 1'b0, 32'd0, 1'b1, 0, r, f);
    check("rmw_result", r, 32'h0000_AA03);
    run_req(1'b1, 32'h400, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 0, r, f);
    check("pmp_store_fault", 32'(f), 32'd2);
    run_req(1'b0, 32'h400, 2'b10, 1'b0, 32'd0, 1'b1, 0, r, f);
    check("pmp_store_blocked", r, 32'h1234_5678);
    run_req(1'b0, 32'h402, 2'b10, 1'b0, 32'd0, 1'b1, 0, r, f);
    check("misaligned_word", 32'(f), 32'd1);
    run_req(1'b0, 32'h000, 2'b11, 1'b0, 32'd0, 1'b1, 0, r, f);
    check("reserved_size", 32'(f), 32'd1);
    run_req(1'b0, 32'h800, 2'b10, 1'b0, 32'd0, 1'b1, 0, r, f);
    check("out_of_range", 32'(f), 32'd2);
    run_req(1'b0, 32'h7FC, 2'b10, 1'b0, 32'd0, 1'b1, 0, r, f);
    run_req(1'b0, 32'h404, 2'b10, 1'b0, 32'd0, 1'b1, 3, r, f);

    // Reset while a word store to 0x010 sits in WRITE.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h010; req_size = 2'b10;
    req_unsigned = 1'b0; req_wdata = 32'h55AA_55AA; chk_ok = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    while (!mem_write && k < 6) begin
      @(negedge clk);
      k++;
    end
    check("reached_write", 32'(mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_drops_write", 32'(mem_write), 32'd0);
    check("rst_drops_read", 32'(mem_read), 32'd0);
    check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 32'(req_ready), 32'd1);
    check("rst_release_no_rsp", 32'(rsp_valid), 32'd0);
    check("aborted_write_word", dm[4], 32'hCAFE_F00D);
    run_req(1'b0, 32'h010, 2'b10, 1'b0, 32'd0, 1'b1, 0, r, f);
    check("aborted_write_reload", r, 32'hCAFE_F00D);

    // Randomized requests around the bottom, the top boundary and beyond.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, 63));
        1:       a = 32'h7C0 + 32'($urandom_range(0, 127));
        2:       a = 32'($urandom_range(0, 2047));
        default: a = $urandom;
      endcase
      run_req(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) != 0),
              $urandom_range(0, 2), r, f);
    end

    nmis = 0;
    for (int i = 0; i < DEPTH; i++)
      if (dm[i] !== ref_mem[i]) nmis++;
    check("mem_image", 32'(nmis), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
